stream_upsizer: RTL

- Parametrised stream width up-converter for the key/data path.
- Collects `RATIO = OUT_WIDTH/IN_WIDTH` narrow input beats and emits one wide output word, with valid/ready handshakes on both sides.
- Supersedes the fixed 32→128 converter: it adds selectable word order and output backpressure, plus optional partial-frame flush.
- Sits between the key/bitstream word source and consumers that need the full-width key (e.g. the 128-bit key register feeding the decryptor).

---
 rtl/stream_upsizer_pkg.sv | 26 ++
 rtl/stream_out_reg.sv | 29 ++
 rtl/stream_upsizer.sv | 118 +++++++++++
 3 files changed

// File: rtl/stream_upsizer_pkg.sv
// rtl/stream_upsizer_pkg.sv - width, counter and slot-placement helpers for stream_upsizer
package stream_upsizer_pkg;

  // Number of narrow beats that make up one wide word.
  function automatic int calc_ratio(input int in_width, input int out_width);
    return out_width / in_width;
  endfunction

  // Width of the beat counter; never narrower than one bit.
  function automatic int cnt_width(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  // The output must be a whole multiple of the input, at least two beats wide.
  function automatic bit widths_legal(input int in_width, input int out_width);
    return (in_width > 0) && (out_width > 0) &&
           ((out_width % in_width) == 0) && ((out_width / in_width) >= 2);
  endfunction

  // Bit offset of the slot receiving beat k of a word.
  function automatic int slot_lsb(input int k, input bit msw_first,
                                  input int ratio, input int in_width);
    return msw_first ? (ratio - 1 - k) * in_width : k * in_width;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - single-entry output holding register with valid/ready drain
module stream_out_reg
  import stream_upsizer_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  // Load a completed word (takes priority over drain); otherwise drop valid once consumed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_data  <= i_data;
      o_valid <= 1'b1;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_upsizer.sv
// rtl/stream_upsizer.sv - narrow-to-wide stream packer; STREAM_UPSIZER_LAST_EN adds frame flush
module stream_upsizer
  import stream_upsizer_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 128,
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [IN_WIDTH-1:0]             s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [OUT_WIDTH-1:0]            m_data,
  output logic                            m_valid,
  input  logic                            m_ready
`ifdef STREAM_UPSIZER_LAST_EN
  ,
  input  logic                            s_last,
  output logic [OUT_WIDTH/IN_WIDTH-1:0]   m_keep,
  output logic                            m_last
`endif
);

  localparam int RATIO = calc_ratio(IN_WIDTH, OUT_WIDTH);
  localparam int CW    = cnt_width(RATIO);
  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);
`ifdef STREAM_UPSIZER_LAST_EN
  localparam int PAY_W = OUT_WIDTH + RATIO + 1;
`else
  localparam int PAY_W = OUT_WIDTH;
`endif

  if (!widths_legal(IN_WIDTH, OUT_WIDTH)) begin : g_width_check
    $error("stream_upsizer: OUT_WIDTH must be a multiple of IN_WIDTH with ratio >= 2");
  end

  logic [CW-1:0]        r_cnt;
  logic                 w_close;
  logic                 w_beat;
  logic                 w_done;
  logic [OUT_WIDTH-1:0] w_word;
  logic [PAY_W-1:0]     w_pay_d;
  logic [PAY_W-1:0]     w_pay_q;
`ifdef STREAM_UPSIZER_LAST_EN
  logic [RATIO-1:0]     w_keep;

  assign w_close = (r_cnt == LAST_CNT) || s_last;
`else
  assign w_close = (r_cnt == LAST_CNT);
`endif

  // A closing beat may only enter when the holding register is free or draining.
  assign s_ready = reset_n && !(w_close && m_valid && !m_ready);
  assign w_beat  = s_valid && s_ready;
  assign w_done  = w_beat && w_close;

  // Per-slot storage and word assembly: current beat goes to slot cnt,
  // earlier slots come from the accumulator, later slots read as zero.
  for (genvar k = 0; k < RATIO; k++) begin : g_slot
    localparam int LSB = slot_lsb(k, MSW_FIRST, RATIO, IN_WIDTH);
    localparam logic [CW-1:0] K = CW'(k);
    logic [IN_WIDTH-1:0] w_prev;

    if (k < RATIO - 1) begin : g_acc
      logic [IN_WIDTH-1:0] r_slot;

      // Capture beat k while the word is still open; stale contents are simply overwritten.
      always_ff @(posedge clk) begin
        if (w_beat && !w_done && (r_cnt == K)) begin
          r_slot <= s_data;
        end
      end

      assign w_prev = r_slot;
    end else begin : g_tail
      assign w_prev = '0;
    end

    assign w_word[LSB +: IN_WIDTH] = (K == r_cnt) ? s_data :
                                     ((K < r_cnt) ? w_prev : '0);
`ifdef STREAM_UPSIZER_LAST_EN
    assign w_keep[LSB / IN_WIDTH] = (K <= r_cnt);
`endif
  end

  // Beat counter: advance on every accepted beat, restart when a word is emitted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_done) begin
      r_cnt <= '0;
    end else if (w_beat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef STREAM_UPSIZER_LAST_EN
  assign w_pay_d = {w_keep, s_last, w_word};
  assign {m_keep, m_last, m_data} = w_pay_q;
`else
  assign w_pay_d = w_word;
  assign m_data  = w_pay_q;
`endif

  stream_out_reg #(
    .WIDTH(PAY_W)
  ) u_out_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_done),
    .i_data  (w_pay_d),
    .i_ready (m_ready),
    .o_data  (w_pay_q),
    .o_valid (m_valid)
  );

endmodule
